id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register for the 5-stage RV32I pipeline. It takes the instruction from IF/ID and drives the register-file read addresses. It bypasses same-cycle write-back data into the read operands, generates immediates and control, and detects load-use hazards.
- The register-file write is visible only after the clock edge, so the bypass is required for correct same-cycle read-after-write.
- Decoded operands and controls are registered toward EX.

Parameters:
- DATA_W, 32, operand/immediate/PC width (RV32: fixed 32, kept as a parameter for checks).
- WB_BYPASS, 1, 1 = enable WB-to-ID operand bypass; 0 = raw register-file data.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_clk_enable  in  1  global stage enable; 0 = hold all state
- i_flush  in  1  branch/jump taken in EX: load bubble into ID/EX
- i_instr  in  32  instruction from IF/ID
- i_pc  in  32  PC of i_instr
- o_rd_addr_1  out  5  to register file, = i_instr[19:15] (combinational)
- o_rd_addr_2  out  5  to register file, = i_instr[24:20] (combinational)
- i_rd_data_1  in  32  register file read port 1
- i_rd_data_2  in  32  register file read port 2
- i_wb_reg_write  in  1  WB stage write strobe (same signal drives the register file)
- i_wb_addr  in  5  WB destination
- i_wb_data  in  32  WB data
- o_stall  out  1  load-use stall: hold PC and IF/ID (combinational)
- o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm  out  32 each  registered to EX
- o_ex_rs1_addr, o_ex_rs2_addr, o_ex_rd  out  5 each  registered, for EX forwarding and WB
- o_ex_funct3  out  3; o_ex_funct7b5  out  1  registered ALU qualifiers
- o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_alu_src, o_ex_branch, o_ex_jump, o_ex_illegal  out  1 each  registered controls
- o_ex_a_sel  out  2  ALU A operand: 00 rs1, 01 pc, 10 zero
- o_ex_wb_sel  out  2  write-back source: 00 alu, 01 mem, 10 pc+4

Behaviour:
- Reset: all o_ex_* outputs are 0 on the first i_clk edge with i_rst=1. i_rst has priority over i_clk_enable.
- Decode by opcode:
  - R 0110011: rd, rs1, rs2 used.
  - I-ALU 0010011: alu_src=1.
  - LOAD 0000011: mem_read, wb_sel=01.
  - STORE 0100011: mem_write, no reg_write.
  - BRANCH 1100011: branch, no reg_write.
  - LUI 0110111: a_sel=10, alu_src=1.
  - AUIPC 0010111: a_sel=01, alu_src=1.
  - JAL 1101111: jump, wb_sel=10.
  - JALR 1100111: jump, alu_src=1, wb_sel=10.
  - Any other opcode: all controls 0, o_ex_illegal=1.
- reg_write=1 for R, I-ALU, LOAD, LUI, AUIPC, JAL and JALR, but forced 0 when rd=0.
- Immediates are sign-extended per standard I/S/B/U/J formats. B and J immediates have bit 0 = 0. U-type immediate = instr[31:12]<<12.
- Usage flags: rs1 is used by R, I-ALU, LOAD, STORE, BRANCH and JALR. rs2 is used by R, STORE and BRANCH.
- Bypass (WB_BYPASS=1): if i_wb_reg_write && i_wb_addr!=0 && i_wb_addr==o_rd_addr_n, operand n = i_wb_data; otherwise operand n = i_rd_data_n. Address x0 always reads 0 regardless of inputs.
- Load-use stall: o_stall = o_ex_mem_read && o_ex_rd!=0 && ((rs1_used && o_ex_rd==rs1) || (rs2_used && o_ex_rd==rs2)).
  - The bubble clears mem_read, so a stall lasts exactly 1 cycle.
  - o_stall is forced 0 when i_flush=1.
- Register update on each edge with i_clk_enable=1, in priority order:
  1. i_rst: reset.
  2. i_flush or o_stall: bubble. All ID/EX fields are loaded with 0 (controls, rd, data, imm, pc, illegal).
  3. Otherwise: load the decoded instruction.
- i_clk_enable=0: all registers hold. o_stall is still evaluated from held state.
- Flush and stall in the same cycle: flush wins, bubble inserted, o_stall=0.
- Reset mid-stall: the next cycle starts from the all-zero state and o_stall=0.
- Latency: 1 cycle from instruction presence to o_ex_* outputs.

Test Plan:
- Reset: i_rst=1 for one edge with any inputs -> all o_ex_*=0, o_stall=0. Deassert, feed ADDI x5,x0,7 (0x00700293) -> next edge: o_ex_rd=5, o_ex_imm=7, reg_write=1, alu_src=1.
- WB bypass: register file returns 0x11 for x3; same cycle i_wb_reg_write=1, addr=3, data=0xDEAD; ADD x4,x3,x3 -> o_ex_rs1_data=o_ex_rs2_data=0xDEAD. Repeat with wb_addr=0 -> no bypass (0x11).
- Load-use: LW x6,0(x1) then ADD x7,x6,x2 -> o_stall=1 for exactly 1 cycle, bubble (all zero) in ID/EX, then ADD issues. A following ADD x7,x8,x2 (no dependency) -> no stall.
- Flush priority: LW x6 in EX, dependent ADD in ID, i_flush=1 -> o_stall=0, bubble loaded.
- Immediates: BEQ with offset -4 (0xFE000EE3) -> o_ex_imm=0xFFFFFFFC, branch=1, reg_write=0. LUI x1,0x12345 -> imm=0x12345000, a_sel=10. JAL x1,+2048 -> imm=0x00000800, wb_sel=10.
- Enable/illegal: i_clk_enable=0 for 3 cycles with changing i_instr -> outputs hold. Opcode 0x7F -> o_ex_illegal=1, all other controls 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register: operand read with WB bypass,
// immediate and control generation, and load-use hazard detection.
module id_ex_stage #(
    parameter int DATA_W    = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_enable,
    input  logic              i_flush,
    input  logic [31:0]       i_instr,
    input  logic [DATA_W-1:0] i_pc,
    output logic [4:0]        o_rd_addr_1,
    output logic [4:0]        o_rd_addr_2,
    input  logic [DATA_W-1:0] i_rd_data_1,
    input  logic [DATA_W-1:0] i_rd_data_2,
    input  logic              i_wb_reg_write,
    input  logic [4:0]        i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_stall,
    output logic [DATA_W-1:0] o_ex_pc,
    output logic [DATA_W-1:0] o_ex_rs1_data,
    output logic [DATA_W-1:0] o_ex_rs2_data,
    output logic [DATA_W-1:0] o_ex_imm,
    output logic [4:0]        o_ex_rs1_addr,
    output logic [4:0]        o_ex_rs2_addr,
    output logic [4:0]        o_ex_rd,
    output logic [2:0]        o_ex_funct3,
    output logic              o_ex_funct7b5,
    output logic              o_ex_reg_write,
    output logic              o_ex_mem_read,
    output logic              o_ex_mem_write,
    output logic              o_ex_alu_src,
    output logic              o_ex_branch,
    output logic              o_ex_jump,
    output logic              o_ex_illegal,
    output logic [1:0]        o_ex_a_sel,
    output logic [1:0]        o_ex_wb_sel
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src;
        logic              branch;
        logic              jump;
        logic              illegal;
        logic [1:0]        a_sel;
        logic [1:0]        wb_sel;
    } ex_t;

    ex_t ex_q;
    ex_t ex_d;
    ex_t dec;

    logic [6:0]        opcode;
    logic              rs1_used;
    logic              rs2_used;
    logic              stall;
    logic [4:0]        rs_addr [2];
    logic [DATA_W-1:0] rs_raw  [2];
    logic [DATA_W-1:0] rs_op   [2];

    assign opcode      = i_instr[6:0];
    assign rs_addr[0]  = i_instr[19:15];
    assign rs_addr[1]  = i_instr[24:20];
    assign rs_raw[0]   = i_rd_data_1;
    assign rs_raw[1]   = i_rd_data_2;
    assign o_rd_addr_1 = rs_addr[0];
    assign o_rd_addr_2 = rs_addr[1];

    // The register file only commits at the edge, so a same-cycle WB write is taken here.
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
        assign rs_op[gi] = (rs_addr[gi] == 5'd0) ? '0 :
                           (WB_BYPASS && i_wb_reg_write && (i_wb_addr == rs_addr[gi])) ? i_wb_data :
                           rs_raw[gi];
    end

    always_comb begin
        dec          = '0;
        dec.pc       = i_pc;
        dec.rs1_data = rs_op[0];
        dec.rs2_data = rs_op[1];
        dec.rs1_addr = rs_addr[0];
        dec.rs2_addr = rs_addr[1];
        dec.rd       = i_instr[11:7];
        dec.funct3   = i_instr[14:12];
        dec.funct7b5 = i_instr[30];
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_I_ALU: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = {{(DATA_W-12){i_instr[31]}}, i_instr[31:20]};
                rs1_used      = 1'b1;
            end
            OP_LOAD: begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.wb_sel    = 2'b01;
                dec.imm       = {{(DATA_W-12){i_instr[31]}}, i_instr[31:20]};
                rs1_used      = 1'b1;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.imm       = {{(DATA_W-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.imm    = {{(DATA_W-12){i_instr[31]}}, i_instr[7], i_instr[30:25],
                              i_instr[11:8], 1'b0};
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.a_sel     = 2'b10;
                dec.imm       = {i_instr[31:12], 12'h000};
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.a_sel     = 2'b01;
                dec.imm       = {i_instr[31:12], 12'h000};
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.wb_sel    = 2'b10;
                dec.imm       = {{(DATA_W-20){i_instr[31]}}, i_instr[19:12], i_instr[20],
                                 i_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.wb_sel    = 2'b10;
                dec.imm       = {{(DATA_W-12){i_instr[31]}}, i_instr[31:20]};
                rs1_used      = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    // A load in EX cannot forward in time to a dependent instruction now in ID.
    assign stall = !i_flush && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                   ((rs1_used && (ex_q.rd == rs_addr[0])) ||
                    (rs2_used && (ex_q.rd == rs_addr[1])));

    always_comb begin
        ex_d = ex_q;
        if (i_clk_enable) begin
            if (i_flush || stall) begin
                ex_d = '0;
            end else begin
                ex_d = dec;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign o_stall        = stall;
    assign o_ex_pc        = ex_q.pc;
    assign o_ex_rs1_data  = ex_q.rs1_data;
    assign o_ex_rs2_data  = ex_q.rs2_data;
    assign o_ex_imm       = ex_q.imm;
    assign o_ex_rs1_addr  = ex_q.rs1_addr;
    assign o_ex_rs2_addr  = ex_q.rs2_addr;
    assign o_ex_rd        = ex_q.rd;
    assign o_ex_funct3    = ex_q.funct3;
    assign o_ex_funct7b5  = ex_q.funct7b5;
    assign o_ex_reg_write = ex_q.reg_write;
    assign o_ex_mem_read  = ex_q.mem_read;
    assign o_ex_mem_write = ex_q.mem_write;
    assign o_ex_alu_src   = ex_q.alu_src;
    assign o_ex_branch    = ex_q.branch;
    assign o_ex_jump      = ex_q.jump;
    assign o_ex_illegal   = ex_q.illegal;
    assign o_ex_a_sel     = ex_q.a_sel;
    assign o_ex_wb_sel    = ex_q.wb_sel;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic against a
// rule-level model of the decode/ID-EX register.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic [31:0] rd1 = 32'h0;
    logic [31:0] rd2 = 32'h0;
    logic        wbw = 1'b0;
    logic [4:0]  wba = 5'd0;
    logic [31:0] wbd = 32'h0;

    logic [4:0]  o_rd_addr_1, o_rd_addr_2, o_ex_rs1_addr, o_ex_rs2_addr, o_ex_rd;
    logic        o_stall, o_ex_funct7b5, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write;
    logic        o_ex_alu_src, o_ex_branch, o_ex_jump, o_ex_illegal;
    logic [31:0] o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm;
    logic [2:0]  o_ex_funct3;
    logic [1:0]  o_ex_a_sel, o_ex_wb_sel;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .i_clk(clk), .i_rst(rst), .i_clk_enable(en), .i_flush(flush),
        .i_instr(instr), .i_pc(pc),
        .o_rd_addr_1(o_rd_addr_1), .o_rd_addr_2(o_rd_addr_2),
        .i_rd_data_1(rd1), .i_rd_data_2(rd2),
        .i_wb_reg_write(wbw), .i_wb_addr(wba), .i_wb_data(wbd),
        .o_stall(o_stall),
        .o_ex_pc(o_ex_pc), .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data),
        .o_ex_imm(o_ex_imm), .o_ex_rs1_addr(o_ex_rs1_addr), .o_ex_rs2_addr(o_ex_rs2_addr),
        .o_ex_rd(o_ex_rd), .o_ex_funct3(o_ex_funct3), .o_ex_funct7b5(o_ex_funct7b5),
        .o_ex_reg_write(o_ex_reg_write), .o_ex_mem_read(o_ex_mem_read),
        .o_ex_mem_write(o_ex_mem_write), .o_ex_alu_src(o_ex_alu_src),
        .o_ex_branch(o_ex_branch), .o_ex_jump(o_ex_jump), .o_ex_illegal(o_ex_illegal),
        .o_ex_a_sel(o_ex_a_sel), .o_ex_wb_sel(o_ex_wb_sel)
    );

    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rd;
        logic [2:0]  f3;
        logic        f7, rw, mr, mw, as, br, jp, il;
        logic [1:0]  asel, wbsel;
    } ex_t;

    ex_t mdl = '0;

    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

    function automatic ex_t dut_ex();
        return {o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm, o_ex_rs1_addr, o_ex_rs2_addr,
                o_ex_rd, o_ex_funct3, o_ex_funct7b5, o_ex_reg_write, o_ex_mem_read,
                o_ex_mem_write, o_ex_alu_src, o_ex_branch, o_ex_jump, o_ex_illegal,
                o_ex_a_sel, o_ex_wb_sel};
    endfunction

    // Register read as the program sees it: x0 is zero, a WB write this cycle wins.
    function automatic logic [31:0] rs_val(input logic [4:0] a, input logic [31:0] raw);
        if (a == 5'd0) return 32'h0;
        if (wbw && wba == a) return wbd;
        return raw;
    endfunction

    function automatic ex_t model_decode();
        ex_t e;
        logic [6:0]  op;
        logic [12:0] b13;
        logic [20:0] j21;
        op   = instr[6:0];
        e    = '0;
        e.pc = pc;
        e.rs1a = instr[19:15];
        e.rs2a = instr[24:20];
        e.rd   = instr[11:7];
        e.f3   = instr[14:12];
        e.f7   = instr[30];
        e.rs1d = rs_val(e.rs1a, rd1);
        e.rs2d = rs_val(e.rs2a, rd2);
        b13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        j21 = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        e.il = !(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67});
        e.rw = (op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) && e.rd != 0;
        e.mr = (op == 7'h03);
        e.mw = (op == 7'h23);
        e.br = (op == 7'h63);
        e.jp = (op inside {7'h6F, 7'h67});
        e.as = (op inside {7'h13, 7'h37, 7'h17, 7'h67});
        e.asel  = (op == 7'h37) ? 2'd2 : (op == 7'h17) ? 2'd1 : 2'd0;
        e.wbsel = (op == 7'h03) ? 2'd1 : e.jp ? 2'd2 : 2'd0;
        if (op inside {7'h13, 7'h03, 7'h67}) e.imm = 32'($signed(instr[31:20]));
        if (op == 7'h23) e.imm = 32'($signed({instr[31:25], instr[11:7]}));
        if (op == 7'h63) e.imm = 32'($signed(b13));
        if (op inside {7'h37, 7'h17}) e.imm = instr[31:12] * 32'h1000;
        if (op == 7'h6F) e.imm = 32'($signed(j21));
        return e;
    endfunction

    function automatic logic model_stall();
        logic [6:0] op;
        logic u1, u2;
        op = instr[6:0];
        u1 = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
        u2 = op inside {7'h33, 7'h23, 7'h63};
        return !flush && mdl.mr && mdl.rd != 0 &&
               ((u1 && mdl.rd == instr[19:15]) || (u2 && mdl.rd == instr[24:20]));
    endfunction

    task automatic tick();
        ex_t nxt;
        if (rst) nxt = '0;
        else if (!en) nxt = mdl;
        else if (flush || model_stall()) nxt = '0;
        else nxt = model_decode();
        @(posedge clk);
        #1;
        mdl = nxt;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; en = 1'b1; flush = 1'b0; wbw = 1'b0; wba = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0;
        instr = 32'h0000A303; pc = $urandom; rd1 = $urandom; rd2 = $urandom;
        tick();
        vectors++;
        if (dut_ex() !== ex_t'('0) || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset: ex=%h stall=%b, required all zero, stall 0", dut_ex(), o_stall);
        end
        idle_inputs();
        instr = 32'h00700293; pc = 32'h100;
        tick();
        vectors++;
        if ({o_ex_rd, o_ex_imm, o_ex_reg_write, o_ex_alu_src} !== {5'd5, 32'd7, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL addi: rd=%0d imm=%h rw=%b as=%b, required rd=5 imm=7 rw=1 as=1",
                     o_ex_rd, o_ex_imm, o_ex_reg_write, o_ex_alu_src);
        end
        vectors++;
        if (dut_ex() !== mdl) begin
            errors++;
            $display("FAIL addi_all: got %h required %h", dut_ex(), mdl);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        instr = 32'h00318233; rd1 = 32'h11; rd2 = 32'h11;
        wbw = 1'b1; wba = 5'd3; wbd = 32'hDEAD;
        tick();
        vectors++;
        if ({o_ex_rs1_data, o_ex_rs2_data} !== {32'hDEAD, 32'hDEAD}) begin
            errors++;
            $display("FAIL bypass: rs1=%h rs2=%h required dead/dead", o_ex_rs1_data, o_ex_rs2_data);
        end
        wba = 5'd0;
        tick();
        vectors++;
        if ({o_ex_rs1_data, o_ex_rs2_data} !== {32'h11, 32'h11}) begin
            errors++;
            $display("FAIL no_bypass_x0: rs1=%h rs2=%h required 11/11", o_ex_rs1_data, o_ex_rs2_data);
        end
        // x0 operand reads zero even with a matching-looking WB and nonzero RF data
        instr = 32'h00000033; wbw = 1'b1; wba = 5'd0; rd1 = 32'h55; rd2 = 32'h66;
        tick();
        vectors++;
        if ({o_ex_rs1_data, o_ex_rs2_data} !== 64'h0) begin
            errors++;
            $display("FAIL x0_read: rs1=%h rs2=%h required 0/0", o_ex_rs1_data, o_ex_rs2_data);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        rd1 = 32'h1234; rd2 = 32'h5678;
        instr = 32'h0000A303; pc = 32'h200;
        tick();
        instr = 32'h002303B3; pc = 32'h204;
        #1;
        vectors++;
        if (o_stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: stall=%b required 1", o_stall);
        end
        tick();
        vectors++;
        if (dut_ex() !== ex_t'('0) || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble: ex=%h stall=%b required zero, stall 0", dut_ex(), o_stall);
        end
        tick();
        vectors++;
        if (o_ex_rd !== 5'd7 || o_ex_pc !== 32'h204 || dut_ex() !== mdl) begin
            errors++;
            $display("FAIL load_use_issue: got %h required %h", dut_ex(), mdl);
        end
        instr = 32'h0000A303; tick();
        instr = 32'h002403B3;
        #1;
        vectors++;
        if (o_stall !== 1'b0) begin
            errors++;
            $display("FAIL no_dep_stall: stall=%b required 0", o_stall);
        end
        // reset in the middle of a stall
        instr = 32'h002303B3; tick();
        instr = 32'h0000A303; tick();
        instr = 32'h002303B3; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (dut_ex() !== ex_t'('0) || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall: ex=%h stall=%b required zero, stall 0", dut_ex(), o_stall);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        instr = 32'h0000A303; tick();
        instr = 32'h002303B3; flush = 1'b1;
        #1;
        vectors++;
        if (o_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: stall=%b required 0", o_stall);
        end
        tick();
        vectors++;
        if (dut_ex() !== ex_t'('0)) begin
            errors++;
            $display("FAIL flush_bubble: ex=%h required zero", dut_ex());
        end
        flush = 1'b0;
    endtask

    task automatic test_immediates();
        idle_inputs();
        instr = 32'hFE000EE3; tick();
        vectors++;
        if ({o_ex_imm, o_ex_branch, o_ex_reg_write} !== {32'hFFFFFFFC, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL beq_imm: imm=%h br=%b rw=%b required fffffffc 1 0",
                     o_ex_imm, o_ex_branch, o_ex_reg_write);
        end
        instr = 32'h123450B7; tick();
        vectors++;
        if ({o_ex_imm, o_ex_a_sel} !== {32'h12345000, 2'b10}) begin
            errors++;
            $display("FAIL lui_imm: imm=%h asel=%b required 12345000 10", o_ex_imm, o_ex_a_sel);
        end
        instr = 32'h001000EF; tick();
        vectors++;
        if ({o_ex_imm, o_ex_wb_sel, o_ex_jump} !== {32'h00000800, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL jal_imm: imm=%h wbsel=%b jump=%b required 800 10 1",
                     o_ex_imm, o_ex_wb_sel, o_ex_jump);
        end
    endtask

    task automatic test_enable();
        ex_t held;
        idle_inputs();
        instr = 32'h00700293; pc = 32'h300; tick();
        held = mdl;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instr = {$urandom} ^ 32'h00000033; pc = $urandom; flush = i[0];
            tick();
            vectors++;
            if (dut_ex() !== held) begin
                errors++;
                $display("FAIL enable_hold[%0d]: got %h required %h", i, dut_ex(), held);
            end
        end
        idle_inputs();
    endtask

    task automatic test_illegal();
        idle_inputs();
        instr = 32'hFFFFFFFF; tick();
        vectors++;
        if ({o_ex_illegal, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_alu_src,
             o_ex_branch, o_ex_jump, o_ex_a_sel, o_ex_wb_sel} !== {1'b1, 10'b0}) begin
            errors++;
            $display("FAIL illegal: il=%b rw=%b mr=%b mw=%b as=%b br=%b jp=%b asel=%b wbsel=%b",
                     o_ex_illegal, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_alu_src,
                     o_ex_branch, o_ex_jump, o_ex_a_sel, o_ex_wb_sel);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            r[6:0]   = ops[$urandom_range(0, 8)];
            r[11:7]  = 5'($urandom_range(0, 7));
            r[19:15] = 5'($urandom_range(0, 7));
            r[24:20] = 5'($urandom_range(0, 7));
            instr = r; pc = $urandom; rd1 = $urandom; rd2 = $urandom;
            wbw = ($urandom_range(0, 1) == 1); wba = 5'($urandom_range(0, 7)); wbd = $urandom;
            flush = ($urandom_range(0, 9) == 0);
            en    = ($urandom_range(0, 9) != 0);
            rst   = ($urandom_range(0, 49) == 0);
            #1;
            vectors++;
            if (o_stall !== model_stall()) begin
                errors++;
                $display("FAIL rand_stall[%0d]: stall=%b required %b", n, o_stall, model_stall());
            end
            tick();
            vectors++;
            if (dut_ex() !== mdl) begin
                errors++;
                $display("FAIL rand_ex[%0d]: got %h required %h", n, dut_ex(), mdl);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_flush();
        test_immediates();
        test_enable();
        test_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
